rr_merge_2to1: RTL and testbench
================================

Name: rr_merge_2to1

Overview:
- Registered, round-robin 2-to-1 stream merge that sits directly upstream of the 100-bit 2:1 data mux.
- Arbitrates between two valid/ready producers (A, B) and generates the select.
- Steers the winning 100-bit word through the select path into a single-entry output register.
- Downstream sees one valid/ready stream, plus a tag saying which source each word came from.

Parameters:
- WIDTH, 100, data width of each input and of the output word.

Ports:
- clk      input   1      rising-edge clock
- rst      input   1      reset; asynchronous, active-high
- a_data   input   WIDTH  source A word
- a_valid  input   1      source A word present
- a_ready  output  1      source A word accepted this cycle (valid & ready = transfer)
- b_data   input   WIDTH  source B word
- b_valid  input   1      source B word present
- b_ready  output  1      source B word accepted this cycle
- y_data   output  WIDTH  registered merged word
- y_valid  output  1      y_data holds an unconsumed word
- y_ready  input   1      downstream accepts y_data this cycle
- y_src    output  1      source of y_data (0 = A, 1 = B); equals the mux select s that produced it

Behaviour:
Reset (rst high, asynchronous; takes effect immediately, independent of clk):
- y_valid = 0, y_data = 0, y_src = 0, last_src = 1.
- Because last_src resets to 1, A wins the first contention.
- Any word held in the output register is discarded.
- a_ready = b_ready = 0 while rst is high.

Output slot state, held implicitly in y_valid:
- EMPTY (y_valid = 0): slot_free = 1.
- FULL (y_valid = 1): slot_free = y_ready.
- slot_free is combinational, so a_ready and b_ready depend combinationally on y_ready. There is no skid buffer.

Grant, combinational, evaluated every cycle:
- Only a_valid: gnt = 0.
- Only b_valid: gnt = 1.
- Both valid: gnt = ~last_src (round-robin).
- Neither valid: no grant; both readies are 0.

Readies:
- a_ready = slot_free & a_valid & (gnt == 0).
- b_ready = slot_free & b_valid & (gnt == 1).
- A non-granted source never sees ready. Ready is never asserted toward an invalid source.

Clock edge:
- Transfer in (a_ready or b_ready): y_data <= gnt ? b_data : a_data; y_src <= gnt; y_valid <= 1; last_src <= gnt.
- No transfer in, and y_ready with y_valid: y_valid <= 0. y_data and y_src hold their last values.
- Otherwise all registers hold.

Timing and throughput:
- Latency is 1 cycle from input transfer to y_valid.
- Full throughput of 1 word/cycle when y_ready is held high. Consume and refill in the same edge is legal.

Boundary conditions:
- Backpressure (y_valid = 1, y_ready = 0): y_data, y_src and y_valid stay stable; both readies are 0; last_src holds.
- Arbitration fairness: last_src updates only on an actual transfer in. A stalled grant does not rotate priority.
- Continuous contention: strict A,B,A,B alternation. Neither source waits more than one granted transfer.
- Producer behaviour: producers may change data while not accepted. The block samples data only on the transfer edge.
- No combinational path from a_data or b_data to any output.

Test Plan:
1. Assert rst mid-stream with y_valid = 1, and release it between clock edges.
   -> y_valid, y_data and y_src go to 0 without waiting for a clock edge.
   -> The next contention with both sources valid grants A.
2. Only A valid, a_data = 100'h1234_5678, y_ready = 1.
   -> Next cycle: y_valid = 1, y_data = 100'h1234_5678, y_src = 0.
   -> b_ready stays 0 throughout.
3. A and B both valid every cycle with incrementing data (A: 0x10, 0x11…; B: 0x20, 0x21…), y_ready = 1.
   -> y_data sequence is 0x10, 0x20, 0x11, 0x21…
   -> y_src alternates 0,1,0,1. One word per cycle.
4. Load a word 0x55 from B, then hold y_ready = 0 for 4 cycles with A valid.
   -> y_data = 0x55 and y_src = 1 stay stable; a_ready = 0 for all 4 cycles.
   -> The cycle y_ready rises, a_ready = 1, and the A word appears on the next edge.
5. Stall while both sources are valid, starting with last_src = 0.
   -> After the stall, B is granted (the stall did not rotate priority).
   -> The scoreboard confirms every accepted word is emitted exactly once, in order, with the correct y_src.
6. 200 cycles of random a_valid, b_valid and y_ready with random data.
   -> The reference model (the 2:1 mux select check: y == a when s = 0, y == b when s = 1) matches every output transfer.
   -> No ready is ever asserted to an invalid source.

Source files
------------

// File: rtl/rr_merge_2to1.sv
// rr_merge_2to1: registered round-robin 2-to-1 valid/ready stream merge with source tag
module rr_merge_2to1 #(
  parameter int WIDTH = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             y_src
);
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_src;
  logic             r_last;
  logic             w_free;
  logic             w_gnt;
  logic             w_xfer;
  // grant and readies; readies are forced low during reset
  always_comb begin
    w_free  = ~r_valid | y_ready;
    w_gnt   = (a_valid & b_valid) ? ~r_last : b_valid;
    a_ready = ~rst & w_free & a_valid & ~w_gnt;
    b_ready = ~rst & w_free & b_valid & w_gnt;
    w_xfer  = a_ready | b_ready;
  end
  // output slot and round-robin history; priority rotates only on a real transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_src   <= 1'b0;
      r_last  <= 1'b1;
    end else if (w_xfer) begin
      r_data  <= w_gnt ? b_data : a_data;
      r_src   <= w_gnt;
      r_valid <= 1'b1;
      r_last  <= w_gnt;
    end else if (y_ready & r_valid) begin
      r_valid <= 1'b0;
    end
  end
  assign y_data  = r_data;
  assign y_valid = r_valid;
  assign y_src   = r_src;
endmodule

// File: tb/tb_rr_merge_2to1.sv
// tb_rr_merge_2to1: directed and random scoreboard bench for rr_merge_2to1
module tb_rr_merge_2to1;
  localparam int W = 100;
  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a_data, b_data, y_data;
  logic         a_valid, a_ready, b_valid, b_ready, y_valid, y_ready, y_src;
  int           tests = 0;
  int           fails = 0;
  logic         m_full, m_last;
  logic [W:0]   q[$];
  logic [W-1:0] ac, bc;
  logic [127:0] rnd_a, rnd_b;

  rr_merge_2to1 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .y_src(y_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one cycle of stimulus, check against the model before the edge, advance the model
  task automatic step(input logic av, input logic [W-1:0] ad, input logic bv,
                      input logic [W-1:0] bd, input logic yr);
    logic free, gnt, ea, eb;
    logic [W:0] e;
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
    @(negedge clk);
    free = !m_full || yr;
    gnt  = (av && bv) ? !m_last : bv;
    ea   = free && av && !gnt;
    eb   = free && bv && gnt;
    chk("a_ready", {99'd0, a_ready}, {99'd0, ea});
    chk("b_ready", {99'd0, b_ready}, {99'd0, eb});
    chk("y_valid", {99'd0, y_valid}, {99'd0, m_full});
    if (m_full) begin
      if (q.size() == 0) chk("scoreboard_empty", 100'd1, 100'd0);
      else begin
        e = q[0];
        chk("y_data", y_data, e[W-1:0]);
        chk("y_src", {99'd0, y_src}, {99'd0, e[W]});
        if (yr) begin
          void'(q.pop_front());
          m_full = 1'b0;
        end
      end
    end
    if (ea || eb) begin
      q.push_back({gnt, gnt ? bd : ad});
      m_full = 1'b1;
      m_last = gnt;
      if (ea) ac = ac + 1'b1;
      if (eb) bc = bc + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_last = 1'b1;
    q.delete();
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; b_valid = 0; y_ready = 0; a_data = '0; b_data = '0;
    model_reset();
    #12;
    chk("rst_y_valid", {99'd0, y_valid}, 100'd0);
    chk("rst_a_ready", {99'd0, a_ready}, 100'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    // load a word and hold it, then reset asynchronously between edges
    step(1, 100'hAB, 1, 100'hCD, 0);
    step(0, '0, 0, '0, 0);
    chk("pre_rst_y_valid", {99'd0, y_valid}, 100'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_y_valid", {99'd0, y_valid}, 100'd0);
    chk("async_y_data", y_data, 100'd0);
    chk("async_y_src", {99'd0, y_src}, 100'd0);
    chk("async_b_ready", {99'd0, b_ready}, 100'd0);
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    step(1, 100'h77, 1, 100'h88, 1);
    step(0, '0, 0, '0, 1);
    // only A valid
    step(1, 100'h1234_5678, 0, '0, 1);
    chk("onlyA_b_ready", {99'd0, b_ready}, 100'd0);
    step(0, '0, 0, '0, 1);
    chk("onlyA_y_data", y_data, 100'h1234_5678);
    chk("onlyA_y_src", {99'd0, y_src}, 100'd0);
    // continuous contention with incrementing data from both sources
    ac = 100'h10; bc = 100'h20;
    for (int i = 0; i < 8; i++) step(1, ac, 1, bc, 1);
    step(0, '0, 0, '0, 1);
    chk("contention_a_count", ac, 100'h14);
    chk("contention_b_count", bc, 100'h24);
    // backpressure with a B word held
    step(0, '0, 1, 100'h55, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 100'h66 + 100'(i), 0, '0, 0);
      chk("bp_y_data", y_data, 100'h55);
      chk("bp_y_src", {99'd0, y_src}, 100'd1);
    end
    step(1, 100'h99, 0, '0, 1);
    step(0, '0, 0, '0, 1);
    chk("bp_release_y_data", y_data, 100'h99);
    // stall with last_src = 0, priority must not rotate
    step(0, '0, 0, '0, 1);
    step(1, 100'hA0, 0, '0, 1);
    for (int i = 0; i < 3; i++) step(1, 100'hA1, 1, 100'hB1, 0);
    step(1, 100'hA1, 1, 100'hB1, 1);
    chk("stall_b_granted_src", {99'd0, m_last}, 100'd1);
    step(0, '0, 0, '0, 1);
    chk("stall_y_src", {99'd0, y_src}, 100'd1);
    chk("stall_y_data", y_data, 100'hB1);
    // random traffic
    for (int i = 0; i < 200; i++) begin
      rnd_a = {$urandom, $urandom, $urandom, $urandom};
      rnd_b = {$urandom, $urandom, $urandom, $urandom};
      step(1'($urandom_range(0, 1)), rnd_a[W-1:0], 1'($urandom_range(0, 1)), rnd_b[W-1:0],
           1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3; i++) step(0, '0, 0, '0, 1);
    chk("drain_queue", 100'(q.size()), 100'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
